instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit_if.sv | 35 +++
 rtl/instruction_fetch_unit.sv | 89 ++++++++
 tb/tb_instruction_fetch_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
// Groups every non-clock, non-reset signal of the instruction fetch unit.
//   master : the fetch unit itself (drives imem_addr and the IF/ID outputs,
//            receives hazard/redirect controls and the instruction word)
//   slave  : the surrounding datapath / instruction memory
// Signals:
//   stall, branch_taken, branch_target, jump, jump_target : control in
//   imem_addr (out) / imem_word (in)                       : instruction memory
//   if_id_instr, if_id_pc_plus4, if_id_valid               : IF/ID register
//   fetch_count                                            : debug counter
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_word;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_target, imem_word,
    output imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target, imem_word,
    input  imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage of the MIPS pipeline: owns the PC, addresses the combinational
// instruction memory, and captures the returned word into IF/ID.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : instruction_fetch_unit_if.master (controls, imem, IF/ID, counter)
// Next-PC priority: jump > branch_taken > stall > sequential (PC+4).
// A redirect always flushes IF/ID, even when stall is also asserted.
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);

  logic [31:0] pc_q,       pc_d;
  logic [31:0] instr_q,    instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q,    valid_d;
  logic [31:0] count_q,    count_d;

  logic [31:0] seq_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  // Sequential address and redirect target; targets are silently word-aligned.
  always_comb begin
    seq_pc   = pc_q + 32'd4;
    redirect = bus.jump | bus.branch_taken;
    if (bus.jump) begin
      redirect_pc = {bus.jump_target[31:2], 2'b00};
    end else begin
      redirect_pc = {bus.branch_target[31:2], 2'b00};
    end
  end

  // Next-state for PC, IF/ID and fetch counter.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    count_d    = count_q;
    if (redirect) begin
      // Flush wins over stall so a squashed slot is never held in decode.
      pc_d       = redirect_pc;
      instr_d    = NOP_WORD;
      pc_plus4_d = 32'h0000_0000;
      valid_d    = 1'b0;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else begin
      pc_d       = seq_pc;
      instr_d    = bus.imem_word;
      pc_plus4_d = seq_pc;
      valid_d    = 1'b1;
      count_d    = count_q + 32'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_WORD;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
      count_q    <= 32'h0000_0000;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc_plus4 = pc_plus4_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.fetch_count    = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br;
  logic [31:0] bt;
  logic        jmp;
  logic [31:0] jt;
  logic [31:0] salt;
  logic        chk_en;

  int n_cmp;
  int n_bad;

  instruction_fetch_unit_if ifa ();
  instruction_fetch_unit_if ifb ();

  // A: default reset PC; B: reset PC near the top of the address space.
  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.master));
  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .NOP_WORD(32'h0000_0000)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.master));

  assign ifa.stall = stall;
  assign ifa.branch_taken = br;
  assign ifa.branch_target = bt;
  assign ifa.jump = jmp;
  assign ifa.jump_target = jt;
  assign ifa.imem_word = ifa.imem_addr ^ salt;
  assign ifb.stall = stall;
  assign ifb.branch_taken = br;
  assign ifb.branch_target = bt;
  assign ifb.jump = jmp;
  assign ifb.jump_target = jt;
  assign ifb.imem_word = ifb.imem_addr ^ salt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: memory word at address a is a ^ salt.
  logic [31:0] m_pc[2], m_instr[2], m_pp4[2], m_cnt[2];
  logic        m_valid[2];
  logic [31:0] rst_pc[2];
  assign rst_pc[0] = 32'h0000_0000;
  assign rst_pc[1] = 32'hFFFF_FFF8;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_pc[k] <= rst_pc[k]; m_instr[k] <= 32'h0; m_pp4[k] <= 32'h0;
        m_valid[k] <= 1'b0; m_cnt[k] <= 32'h0;
      end else if (jmp || br) begin
        m_pc[k] <= (jmp ? jt : bt) & 32'hFFFF_FFFC;
        m_instr[k] <= 32'h0; m_pp4[k] <= 32'h0; m_valid[k] <= 1'b0;
      end else if (!stall) begin
        m_instr[k] <= m_pc[k] ^ salt;
        m_pp4[k]   <= m_pc[k] + 32'd4;
        m_valid[k] <= 1'b1;
        m_cnt[k]   <= m_cnt[k] + 32'd1;
        m_pc[k]    <= m_pc[k] + 32'd4;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pin both DUT and model to a hand-computed literal.
  task automatic pin(input string name, input logic [31:0] dut, input logic [31:0] mdl,
                     input logic [31:0] lit);
    check({name, ".dut"}, dut, lit);
    check({name, ".model"}, mdl, lit);
  endtask

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("A.imem_addr", ifa.imem_addr, m_pc[0]);
      check("A.instr", ifa.if_id_instr, m_instr[0]);
      check("A.pc_plus4", ifa.if_id_pc_plus4, m_pp4[0]);
      check("A.valid", {31'd0, ifa.if_id_valid}, {31'd0, m_valid[0]});
      check("A.count", ifa.fetch_count, m_cnt[0]);
      check("B.imem_addr", ifb.imem_addr, m_pc[1]);
      check("B.instr", ifb.if_id_instr, m_instr[1]);
      check("B.pc_plus4", ifb.if_id_pc_plus4, m_pp4[1]);
      check("B.valid", {31'd0, ifb.if_id_valid}, {31'd0, m_valid[1]});
      check("B.count", ifb.fetch_count, m_cnt[1]);
    end
  end

  // Apply inputs for the next rising edge, then return at the following falling edge.
  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] btv,
                     input logic j, input logic [31:0] jtv);
    reset = r; stall = s; br = b; bt = btv; jmp = j; jt = jtv;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 1'b0; salt = 32'h0;
    reset = 1'b1; stall = 1'b0; br = 1'b0; bt = 32'h0; jmp = 1'b0; jt = 32'h0;
    @(negedge clk);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_en = 1'b1;
    pin("rst.addr", ifa.imem_addr, m_pc[0], 32'h0);
    pin("rst.valid", {31'd0, ifa.if_id_valid}, {31'd0, m_valid[0]}, 32'h0);
    pin("rst.count", ifa.fetch_count, m_cnt[0], 32'h0);
    pin("rst.B.addr", ifb.imem_addr, m_pc[1], 32'hFFFF_FFF8);

    // Free run: A fetches 0,4,...; B wraps through 0xFFFF_FFFC.
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    pin("wrap.B.addr", ifb.imem_addr, m_pc[1], 32'h0000_0000);
    pin("wrap.B.pp4", ifb.if_id_pc_plus4, m_pp4[1], 32'h0000_0000);
    pin("wrap.B.instr", ifb.if_id_instr, m_instr[1], 32'hFFFF_FFFC);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    pin("seq.addr", ifa.imem_addr, m_pc[0], 32'h10);
    pin("seq.instr", ifa.if_id_instr, m_instr[0], 32'hC);
    pin("seq.pp4", ifa.if_id_pc_plus4, m_pp4[0], 32'h10);
    pin("seq.count", ifa.fetch_count, m_cnt[0], 32'd4);
    pin("seq.valid", {31'd0, ifa.if_id_valid}, {31'd0, m_valid[0]}, 32'h1);

    // Stall at PC=0x08.
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    pin("stall.addr", ifa.imem_addr, m_pc[0], 32'h8);
    pin("stall.instr", ifa.if_id_instr, m_instr[0], 32'h4);
    pin("stall.count", ifa.fetch_count, m_cnt[0], 32'd2);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    pin("resume.instr", ifa.if_id_instr, m_instr[0], 32'h8);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Branch at PC=0x10 to 0x40.
    cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    pin("br.addr", ifa.imem_addr, m_pc[0], 32'h40);
    pin("br.valid", {31'd0, ifa.if_id_valid}, {31'd0, m_valid[0]}, 32'h0);
    pin("br.count", ifa.fetch_count, m_cnt[0], 32'd4);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    pin("br.next.instr", ifa.if_id_instr, m_instr[0], 32'h40);
    pin("br.next.pp4", ifa.if_id_pc_plus4, m_pp4[0], 32'h44);

    // Jump + branch + stall together, then a misaligned jump target.
    cyc(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80);
    pin("jmp.addr", ifa.imem_addr, m_pc[0], 32'h80);
    pin("jmp.valid", {31'd0, ifa.if_id_valid}, {31'd0, m_valid[0]}, 32'h0);
    pin("jmp.pp4", ifa.if_id_pc_plus4, m_pp4[0], 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h83);
    pin("misalign.addr", ifa.imem_addr, m_pc[0], 32'h80);

    // Reset during a stall after 5 fetches.
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    pin("pre.count", ifa.fetch_count, m_cnt[0], 32'd5);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    pin("rs.addr", ifa.imem_addr, m_pc[0], 32'h0);
    pin("rs.count", ifa.fetch_count, m_cnt[0], 32'h0);
    pin("rs.valid", {31'd0, ifa.if_id_valid}, {31'd0, m_valid[0]}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    pin("rs.first.valid", {31'd0, ifa.if_id_valid}, {31'd0, m_valid[0]}, 32'h1);
    pin("rs.first.pp4", ifa.if_id_pc_plus4, m_pp4[0], 32'h4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      salt = $urandom;
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 7) == 0), $urandom,
          ($urandom_range(0, 15) == 0), $urandom);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
